sa_sched_ctrl: RTL and testbench
================================

Name: sa_sched_ctrl

Overview:
Sequencer for a ROWS x COLS systolic array of processing elements. On a start/busy/done handshake it runs four phases: weight loading, skewed streaming of activations, draining of partial sums and completion. In streaming it drives a per-row enable so that row r runs r cycles after row 0. It also generates right-edge output-valid strobes, counts total integer ops and keeps a sticky OR of the PE overflow flags. It sits between the top-level command interface and the PE grid.

Parameters:
ROWS, 4, number of PE rows (>=1)
COLS, 4, number of PE columns (>=1)
MAX_K, 256, maximum stream length, in activation vectors per job
KW, $clog2(MAX_K+1), width of k_len

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  job request; sampled only in IDLE
abort  in  1  cancel the current job
k_len  in  KW  stream length K; latched on an accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
w_load_en  out  1  weight-load strobe to the grid
w_row_sel  out  $clog2(ROWS) (min 1)  row being loaded
act_idx  out  KW+$clog2(ROWS)+1  stream cycle counter t, used as the activation buffer address
row_enable  out  ROWS  per-row PE enable
out_valid  out  ROWS  right-edge result valid, one bit per row
ops_total  out  32  integer ops issued in the current job
ovf_in  in  ROWS*COLS  overflow flags from the PEs
ovf_sticky  out  1  OR of ovf_in, sampled while the job is busy

Behaviour:
- Reset (asynchronous, active-high) forces the following values:
  - state = IDLE
  - all outputs = 0
  - internal counters and the delay line = 0
- States are IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 with k_len in 1..MAX_K: latch K, clear ops_total and ovf_sticky, go to LOAD_W.
  - start=1 with k_len=0 or k_len>MAX_K: go directly to DONE. No enables are issued; done pulses next cycle.
- LOAD_W lasts ROWS cycles:
  - w_load_en=1 throughout.
  - w_row_sel steps 0..ROWS-1.
  - Then go to STREAM with t=0.
- STREAM:
  - t counts 0..K+ROWS-2; act_idx=t.
  - row_enable[r] = (t>=r) && (t<r+K), registered outputs.
  - When t=K+ROWS-2, go to DRAIN.
- DRAIN lasts COLS cycles:
  - row_enable=0.
  - The delay line flushes during this phase.
  - Then go to DONE.
- DONE lasts 1 cycle: done=1, then go to IDLE. busy falls in the same cycle as the IDLE entry.
- Cycle count from an accepted start: done is high in cycle 2*ROWS+K+COLS after the start edge.
- out_valid[r] is row_enable[r] delayed by exactly COLS cycles, through a shift register per row.
- ops_total adds 2*COLS*popcount(row_enable) each cycle and saturates at 2^32-1.
- ovf_sticky |= |ovf_in on every cycle while busy. It is held after done and cleared on the next accepted start.
- Abort, in any busy state:
  - Next state is IDLE.
  - row_enable, w_load_en and out_valid, including the delay line, are cleared on the next edge.
  - No done pulse.
  - ops_total and ovf_sticky are held.
- abort in IDLE is ignored. If abort and start arrive in the same cycle in IDLE, start wins.
- start while busy is ignored; no queueing.
- Reset asserted mid-job returns the block to the reset state immediately. No done pulse is produced.

Decomposition:
- Package sa_ctrl_pkg holds:
  - the state enum sa_state_t (IDLE, LOAD_W, STREAM, DRAIN, DONE);
  - OPS_PER_MAC = 2.
- Sub-module sa_delay_line, parameters WIDTH and DEPTH: a synchronous shift register with asynchronous reset and a synchronous flush input. It is instantiated once (WIDTH=ROWS, DEPTH=COLS) to produce out_valid.

Test Plan:
- Reset mid-STREAM (ROWS=COLS=4, K=8) -> all outputs 0 immediately, state IDLE; a subsequent start runs a normal job.
- Nominal job, ROWS=COLS=4, K=8, start at cycle 0:
  - w_load_en for cycles 1..4, w_row_sel 0..3;
  - row_enable[0] high for cycles 5..12, row_enable[3] high for cycles 8..15;
  - out_valid[0] high for cycles 9..16;
  - done high at cycle 20 only;
  - ops_total = 256.
- k_len=0 start -> done at cycle 1, busy high for cycle 1 only, row_enable never set, ops_total=0.
- Abort in STREAM at t=3 -> next cycle IDLE, row_enable and out_valid = 0, no done, ops_total held at its value.
- Overflow and restart:
  - ovf_in bit 5 pulses for one cycle in STREAM -> ovf_sticky=1 through done and after;
  - a new start clears it.
- Start held high through a job -> start ignored while busy; the next job begins the cycle after IDLE is re-entered. abort together with start in IDLE -> job starts.

Source files
------------

// File: rtl/sa_ctrl_pkg.sv
// Shared types and constants for the systolic-array scheduler.
//   sa_state_t  : sequencer phases
//   OPS_PER_MAC : integer ops counted per PE per enabled cycle (multiply + add)
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sa_state_t;

  localparam int unsigned OPS_PER_MAC = 2;

endpackage

// File: rtl/sa_delay_line.sv
// Per-bit shift register of DEPTH stages with a synchronous flush.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : clears every stage on the next edge
//   d        : input word, q : d delayed by exactly DEPTH cycles
module sa_delay_line #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift chain; stage[0] takes the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/sa_sched_ctrl.sv
// Sequencer for a ROWS x COLS systolic array: weight load, skewed activation
// stream, drain, done. Also produces right-edge valid strobes, an op counter
// and a sticky overflow flag.
//   start/abort/k_len     : job command (start sampled only in IDLE)
//   busy/done             : job status, done is a one-cycle pulse
//   w_load_en/w_row_sel   : weight-load strobe and row index
//   act_idx               : stream cycle counter t (activation buffer address)
//   row_enable/out_valid  : per-row PE enable and its COLS-cycle delayed copy
//   ops_total             : saturating integer-op count of the current job
//   ovf_in/ovf_sticky     : PE overflow flags and their sticky OR
module sa_sched_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned MAX_K = 256,
  parameter int unsigned KW    = $clog2(MAX_K + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [KW-1:0]                     k_len,
  output logic                              busy,
  output logic                              done,
  output logic                              w_load_en,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] w_row_sel,
  output logic [KW+$clog2(ROWS)+1-1:0]      act_idx,
  output logic [ROWS-1:0]                   row_enable,
  output logic [ROWS-1:0]                   out_valid,
  output logic [31:0]                       ops_total,
  input  logic [ROWS*COLS-1:0]              ovf_in,
  output logic                              ovf_sticky
);

  localparam int unsigned RSW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TW      = KW + $clog2(ROWS) + 1;
  localparam int unsigned CNT_MAX = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PCW     = $clog2(ROWS + 1);

  sa_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]   t_nxt, t_last;
  logic [KW-1:0]   k_q;
  logic [ROWS-1:0] row_enable_nxt;
  logic            k_ok;
  logic            accept;
  logic            kill;
  logic [PCW-1:0]  pop;
  logic [31:0]     ops_inc;
  logic [32:0]     ops_sum;

  assign k_ok   = (k_len != '0) && (k_len <= KW'(MAX_K));
  assign accept = (state == IDLE) && start;
  assign kill   = (state != IDLE) && abort;
  assign t_last = TW'(k_q) + TW'(ROWS) - TW'(2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, phase counters and next row enables.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    t_nxt          = '0;
    row_enable_nxt = '0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt   = '0;
          state_nxt = k_ok ? LOAD_W : DONE;
        end
      end
      LOAD_W: begin
        if (cnt == CW'(ROWS - 1)) begin
          state_nxt = STREAM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STREAM: begin
        if (act_idx == t_last) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          t_nxt = act_idx + TW'(1);
        end
      end
      DRAIN: begin
        if (cnt == CW'(COLS - 1)) state_nxt = DONE;
        else                      cnt_nxt   = cnt + CW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      t_nxt     = '0;
    end
    // Row r sees activation vectors r cycles after row 0.
    for (int unsigned r = 0; r < ROWS; r++) begin
      row_enable_nxt[r] = (state_nxt == STREAM) && (t_nxt >= TW'(r)) &&
                          (t_nxt < TW'(r) + TW'(k_q));
    end
  end

  // Ops issued this cycle: every enabled row fires COLS PEs.
  always_comb begin
    pop = '0;
    for (int unsigned r = 0; r < ROWS; r++) pop = pop + PCW'(row_enable[r]);
    ops_inc = 32'(OPS_PER_MAC * COLS) * 32'(pop);
    ops_sum = 33'(ops_total) + 33'(ops_inc);
  end

  // Registered outputs and job bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      k_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      w_load_en  <= 1'b0;
      w_row_sel  <= '0;
      act_idx    <= '0;
      row_enable <= '0;
      ops_total  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      w_load_en  <= (state_nxt == LOAD_W);
      w_row_sel  <= (state_nxt == LOAD_W) ? RSW'(cnt_nxt) : '0;
      act_idx    <= t_nxt;
      row_enable <= row_enable_nxt;
      if (accept) begin
        k_q        <= k_len;
        ops_total  <= '0;
        ovf_sticky <= 1'b0;
      end else if ((state != IDLE) && !abort) begin
        // Abort freezes the job statistics as they stood.
        ops_total  <= ops_sum[32] ? '1 : ops_sum[31:0];
        ovf_sticky <= ovf_sticky | (|ovf_in);
      end
    end
  end

  sa_delay_line #(
    .WIDTH (ROWS),
    .DEPTH (COLS)
  ) u_valid_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (kill),
    .d     (row_enable),
    .q     (out_valid)
  );

endmodule

// File: tb/tb_sa_sched_ctrl.sv
// Scoreboard bench for sa_sched_ctrl (ROWS=COLS=4, MAX_K=256).
module tb_sa_sched_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int MAX_K = 256;
  localparam int KW    = 9;
  localparam int RSW   = 2;
  localparam int TW    = KW + 2 + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [KW-1:0]    k_len;
  logic             busy;
  logic             done;
  logic             w_load_en;
  logic [RSW-1:0]   w_row_sel;
  logic [TW-1:0]    act_idx;
  logic [ROWS-1:0]  row_enable;
  logic [ROWS-1:0]  out_valid;
  logic [31:0]      ops_total;
  logic [ROWS*COLS-1:0] ovf_in;
  logic             ovf_sticky;

  sa_sched_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_K(MAX_K)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .w_load_en  (w_load_en),
    .w_row_sel  (w_row_sel),
    .act_idx    (act_idx),
    .row_enable (row_enable),
    .out_valid  (out_valid),
    .ops_total  (ops_total),
    .ovf_in     (ovf_in),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int v;
    int v2;
  } ev_t;

  ev_t wl_q[$];
  ev_t re_q[$];
  ev_t ov_q[$];
  ev_t dn_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events of a job whose start is driven during cycle e.
  // t_stop >= 0 truncates the stream (abort/reset) and drops tail events.
  task automatic push_job(input int e, input int k, input int ops, input int ovf,
                          input int t_stop);
    int pat;
    int t_end;
    for (int c = 0; c < ROWS; c++) wl_q.push_back('{e + 1 + c, c, 0});
    t_end = (t_stop >= 0) ? t_stop : k + ROWS - 2;
    for (int t = 0; t <= t_end; t++) begin
      pat = 0;
      for (int r = 0; r < ROWS; r++)
        if (t >= r && t < r + k) pat = pat | (1 << r);
      re_q.push_back('{e + ROWS + 1 + t, pat, t});
      if (t_stop < 0) ov_q.push_back('{e + ROWS + 1 + t + COLS, pat, 0});
    end
    if (t_stop < 0) dn_q.push_back('{e + 2 * ROWS + k + COLS, ops, ovf});
  endtask

  task automatic launch(input int k, input int ops, input int ovf, input int t_stop,
                        output int e);
    @(negedge clk);
    e = cyc;
    if (k >= 1 && k <= MAX_K) push_job(e, k, ops, ovf, t_stop);
    else                      dn_q.push_back('{e + 1, ops, ovf});
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (w_load_en) begin
        if (wl_q.size() == 0) chk("wl_unexpected_cycle", cyc, -1);
        else begin
          e = wl_q.pop_front();
          chk("wl_cycle", cyc, e.cyc);
          chk("w_row_sel", int'(w_row_sel), e.v);
        end
      end
      if (row_enable != '0) begin
        if (re_q.size() == 0) chk("row_en_unexpected_cycle", cyc, -1);
        else begin
          e = re_q.pop_front();
          chk("row_en_cycle", cyc, e.cyc);
          chk("row_enable", int'(row_enable), e.v);
          chk("act_idx", int'(act_idx), e.v2);
        end
      end
      if (out_valid != '0) begin
        if (ov_q.size() == 0) chk("out_valid_unexpected_cycle", cyc, -1);
        else begin
          e = ov_q.pop_front();
          chk("out_valid_cycle", cyc, e.cyc);
          chk("out_valid", int'(out_valid), e.v);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) chk("done_unexpected_cycle", cyc, -1);
        else begin
          e = dn_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_ops_total", int'(ops_total), e.v);
          chk("done_ovf_sticky", int'(ovf_sticky), e.v2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    int e2;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    k_len  = '0;
    ovf_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_row_enable", int'(row_enable), 0);
    chk("reset_ops_total", int'(ops_total), 0);
    rst = 1'b0;

    // Empty and oversized jobs: straight to DONE, one busy cycle.
    launch(0, 0, 0, -1, e);
    chk("k0_busy_c1", int'(busy), 1);
    @(negedge clk);
    chk("k0_busy_c2", int'(busy), 0);
    chk("k0_ops_total", int'(ops_total), 0);
    launch(300, 0, 0, -1, e);
    chk("kbig_busy_c1", int'(busy), 1);
    @(negedge clk);
    chk("kbig_busy_c2", int'(busy), 0);

    // Nominal K=8 job with hand-timed spot checks.
    launch(8, 256, 0, -1, e);
    chk("nom_wl_c1", int'(w_load_en), 1);
    wait_cyc(e + 5);
    chk("nom_wl_c5", int'(w_load_en), 0);
    wait_cyc(e + 12);
    chk("nom_row0_c12", int'(row_enable[0]), 1);
    wait_cyc(e + 13);
    chk("nom_row0_c13", int'(row_enable[0]), 0);
    chk("nom_row3_c13", int'(row_enable[3]), 1);
    wait_cyc(e + 16);
    chk("nom_ov0_c16", int'(out_valid[0]), 1);
    wait_cyc(e + 17);
    chk("nom_ov0_c17", int'(out_valid[0]), 0);
    wait_cyc(e + 20);
    chk("nom_done_c20", int'(done), 1);
    wait_cyc(e + 21);
    chk("nom_busy_c21", int'(busy), 0);
    chk("nom_ops_total", int'(ops_total), 256);

    // Reset mid-stream, then a normal job.
    launch(8, 0, 0, 2, e);
    wait_cyc(e + 7);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_row_enable", int'(row_enable), 0);
    chk("rst_mid_act_idx", int'(act_idx), 0);
    chk("rst_mid_ops_total", int'(ops_total), 0);
    @(negedge clk);
    rst = 1'b0;
    launch(8, 256, 0, -1, e);
    wait_cyc(e + 22);

    // Abort at t=3: ops from t=0..2 only (8*(1+2+3)).
    launch(8, 0, 0, 3, e);
    wait_cyc(e + 8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_row_enable", int'(row_enable), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_ops_total", int'(ops_total), 48);
    repeat (8) @(negedge clk);
    chk("abort_ops_held", int'(ops_total), 48);
    chk("abort_no_done", int'(done), 0);

    // Overflow pulse in STREAM, sticky through done, cleared by next start.
    launch(8, 256, 1, -1, e);
    wait_cyc(e + 7);
    ovf_in = 16'h0020;
    @(negedge clk);
    ovf_in = '0;
    wait_cyc(e + 23);
    chk("ovf_after_done", int'(ovf_sticky), 1);
    launch(2, 64, 0, -1, e2);
    chk("ovf_cleared", int'(ovf_sticky), 0);
    wait_cyc(e2 + 16);

    // Start held through a K=3 job; abort+start in IDLE starts the next one.
    @(negedge clk);
    e = cyc;
    push_job(e, 3, 96, 0, -1);
    push_job(e + 16, 3, 96, 0, -1);
    start = 1'b1;
    k_len = KW'(3);
    wait_cyc(e + 16);
    chk("held_idle_busy", int'(busy), 0);
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("held_restart_busy", int'(busy), 1);
    wait_cyc(e + 36);

    chk("wl_q_left", wl_q.size(), 0);
    chk("re_q_left", re_q.size(), 0);
    chk("ov_q_left", ov_q.size(), 0);
    chk("dn_q_left", dn_q.size(), 0);
    chk("end_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
